// File: rtl/decrypt_pipe_if.sv
// Byte/key/output bundle for the decrypt one-hot stage.
// master: upstream driver and downstream consumer; slave: the stage itself.
interface decrypt_pipe_if;
  logic        en;
  logic        mode;
  logic [7:0]  din;
  logic [7:0]  k1;
  logic [7:0]  k2;
  logic [7:0]  k3;
  logic [2:0]  rot_freq;
  logic        restart;

  logic        en_out;
  logic        mode_out;
  logic [31:0] extended_shift_out;
  logic [3:0]  shift_amt_out;
  logic        shift_en_out;
  logic        is_alpha_upper_case_out;
  logic        is_alpha_low_case_out;

  modport master (
    output en, mode, din, k1, k2, k3, rot_freq, restart,
    input  en_out, mode_out, extended_shift_out, shift_amt_out,
           shift_en_out, is_alpha_upper_case_out, is_alpha_low_case_out
  );

  modport slave (
    input  en, mode, din, k1, k2, k3, rot_freq, restart,
    output en_out, mode_out, extended_shift_out, shift_amt_out,
           shift_en_out, is_alpha_upper_case_out, is_alpha_low_case_out
  );
endinterface

// File: rtl/decrypt_pipe_onehot.sv
// Decrypt stage ahead of shift/decode: classifies each byte, builds a
// one-hot letter code pre-rotated by a multiple of 7, and leaves a residual
// shift of 0..6 for the next stage. One registered stage, no back-pressure.
// Optional feature macro: DECRYPT_KEY_ROT_EN (rotating k1/k2/k3 schedule).
// Without it the active key is always k1.
//
// key_idx | meaning
// KEY_1   | k1 active
// KEY_2   | k2 active
// KEY_3   | k3 active
module decrypt_pipe_onehot (
  input  logic          clk,
  input  logic          rst,
  decrypt_pipe_if.slave bus
);

  localparam logic [1:0] KEY_1 = 2'd0;
  localparam logic [1:0] KEY_2 = 2'd1;
  localparam logic [1:0] KEY_3 = 2'd2;

  logic        is_upper;
  logic        is_lower;
  logic        is_letter;
  logic        active;
  logic        advance;
  logic [4:0]  idx;
  logic [7:0]  key_sel;
  logic [4:0]  key_mod;
  logic [4:0]  off;
  logic [4:0]  coarse;
  logic [3:0]  resid;
  logic [5:0]  pos_sum;
  logic [4:0]  pos;
  logic [25:0] onehot;

  assign is_upper  = (bus.din >= 8'd65) && (bus.din <= 8'd90);
  assign is_lower  = (bus.din >= 8'd97) && (bus.din <= 8'd122);
  assign is_letter = is_upper || is_lower;
  assign active    = bus.en && bus.mode;
  assign advance   = active && is_letter;
  // 'A' and 'a' both end in 5'b00001, so the low five bits minus one give 0..25.
  assign idx       = bus.din[4:0] - 5'd1;

`ifdef DECRYPT_KEY_ROT_EN
  logic [2:0] cnt;
  logic [1:0] key_idx;
  logic [2:0] cnt_base;
  logic [1:0] key_base;

  // Restart rewinds the schedule before this cycle's letter is counted.
  assign cnt_base = bus.restart ? 3'd0 : cnt;
  assign key_base = bus.restart ? KEY_1 : key_idx;

  // Pick the key for the current byte from the (possibly rewound) schedule.
  always_comb begin
    case (key_base)
      KEY_2:   key_sel = bus.k2;
      KEY_3:   key_sel = bus.k3;
      default: key_sel = bus.k1;
    endcase
  end

  // Advance the letter counter and rotate keys after rot_freq+1 letters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      key_idx <= KEY_1;
    end else if (advance) begin
      if (cnt_base == bus.rot_freq) begin
        cnt     <= 3'd0;
        key_idx <= (key_base == KEY_3) ? KEY_1 : key_base + 2'd1;
      end else begin
        cnt     <= cnt_base + 3'd1;
        key_idx <= key_base;
      end
    end else begin
      cnt     <= cnt_base;
      key_idx <= key_base;
    end
  end
`else
  logic unused_sched;
  assign unused_sched = ^{bus.k2, bus.k3, bus.rot_freq, bus.restart, KEY_2, KEY_3};
  assign key_sel = bus.k1;
`endif

  // Split the decrypt offset into a coarse multiple of 7 and a 0..6 residual,
  // then rotate the one-hot code left by the coarse part modulo 26.
  always_comb begin
    key_mod = 5'(key_sel % 8'd26);
    off     = (key_mod == 5'd0) ? 5'd0 : 5'd26 - key_mod;
    if (off >= 5'd21)      coarse = 5'd21;
    else if (off >= 5'd14) coarse = 5'd14;
    else if (off >= 5'd7)  coarse = 5'd7;
    else                   coarse = 5'd0;
    resid   = 4'(off - coarse);
    pos_sum = {1'b0, idx} + {1'b0, coarse};
    pos     = (pos_sum >= 6'd26) ? 5'(pos_sum - 6'd26) : pos_sum[4:0];
    onehot  = 26'd1 << pos;
  end

  // Output register: letter code, raw byte passthrough, or zeros when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.en_out                  <= 1'b0;
      bus.mode_out                <= 1'b0;
      bus.extended_shift_out      <= 32'd0;
      bus.shift_amt_out           <= 4'd0;
      bus.shift_en_out            <= 1'b0;
      bus.is_alpha_upper_case_out <= 1'b0;
      bus.is_alpha_low_case_out   <= 1'b0;
    end else begin
      bus.en_out   <= bus.en;
      bus.mode_out <= bus.mode;
      if (advance) begin
        bus.extended_shift_out      <= {6'd0, onehot};
        bus.shift_amt_out           <= resid;
        bus.shift_en_out            <= 1'b1;
        bus.is_alpha_upper_case_out <= is_upper;
        bus.is_alpha_low_case_out   <= is_lower;
      end else begin
        bus.extended_shift_out      <= active ? {24'd0, bus.din} : 32'd0;
        bus.shift_amt_out           <= 4'd0;
        bus.shift_en_out            <= 1'b0;
        bus.is_alpha_upper_case_out <= 1'b0;
        bus.is_alpha_low_case_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decrypt_pipe_onehot.sv
// Directed bench for decrypt_pipe_onehot; expectations are hand-computed.
module tb_decrypt_pipe_onehot;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decrypt_pipe_if bus();

  decrypt_pipe_onehot dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive(input logic e, input logic m, input logic [7:0] d);
    bus.en   = e;
    bus.mode = m;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_restart();
    bus.restart = 1'b1;
    drive(1'b0, 1'b1, 8'd0);
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd65);
    drive(1'b1, 1'b1, 8'd65);
    n_checks++;
    if (bus.extended_shift_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ext got %h want %h", bus.extended_shift_out, 32'd0);
    end
    n_checks++;
    if (bus.shift_amt_out !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_amt got %0d want 0", bus.shift_amt_out);
    end
    n_checks++;
    if ({bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
         bus.en_out, bus.mode_out} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
                bus.en_out, bus.mode_out});
    end
    rst = 1'b0;
  endtask

  task automatic test_letters();
    bus.k1 = 8'd3;
    drive(1'b1, 1'b1, 8'd68);
    n_checks++;
    if (bus.extended_shift_out !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL D_k3_ext got %h want 01000000", bus.extended_shift_out);
    end
    n_checks++;
    if (bus.shift_amt_out !== 4'd2) begin
      n_fail++;
      $display("FAIL D_k3_amt got %0d want 2", bus.shift_amt_out);
    end
    n_checks++;
    if ({bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
         bus.en_out, bus.mode_out} !== 5'b11011) begin
      n_fail++;
      $display("FAIL D_k3_flags got %b want 11011",
               {bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
                bus.en_out, bus.mode_out});
    end

    bus.k1 = 8'd0;
    drive(1'b1, 1'b1, 8'd122);
    n_checks++;
    if (bus.extended_shift_out !== 32'h0200_0000) begin
      n_fail++;
      $display("FAIL z_k0_ext got %h want 02000000", bus.extended_shift_out);
    end
    n_checks++;
    if (bus.shift_amt_out !== 4'd0) begin
      n_fail++;
      $display("FAIL z_k0_amt got %0d want 0", bus.shift_amt_out);
    end
    n_checks++;
    if ({bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL z_k0_flags got %b want 101",
               {bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out});
    end

    bus.k1 = 8'd255;
    drive(1'b1, 1'b1, 8'd97);
    n_checks++;
    if (bus.extended_shift_out !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL a_k255_ext got %h want 00000001", bus.extended_shift_out);
    end
    n_checks++;
    if (bus.shift_amt_out !== 4'd5) begin
      n_fail++;
      $display("FAIL a_k255_amt got %0d want 5", bus.shift_amt_out);
    end
  endtask

  task automatic test_nonletter();
    logic [31:0] exp_ext;
    logic [3:0]  exp_amt;
    bus.rot_freq = 3'd0;
    bus.k1 = 8'd3;
    bus.k2 = 8'd0;
    bus.k3 = 8'd255;
    idle_restart();
    drive(1'b1, 1'b1, 8'd68);
    n_checks++;
    if (bus.shift_amt_out !== 4'd2) begin
      n_fail++;
      $display("FAIL nl_pre_amt got %0d want 2", bus.shift_amt_out);
    end
    drive(1'b1, 1'b1, 8'd33);
    n_checks++;
    if (bus.extended_shift_out !== 32'h0000_0021) begin
      n_fail++;
      $display("FAIL nl_ext got %h want 00000021", bus.extended_shift_out);
    end
    n_checks++;
    if ({bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
         bus.en_out, bus.mode_out} !== 5'b00011) begin
      n_fail++;
      $display("FAIL nl_flags got %b want 00011",
               {bus.shift_en_out, bus.is_alpha_upper_case_out, bus.is_alpha_low_case_out,
                bus.en_out, bus.mode_out});
    end
    n_checks++;
    if (bus.shift_amt_out !== 4'd0) begin
      n_fail++;
      $display("FAIL nl_amt got %0d want 0", bus.shift_amt_out);
    end
`ifdef DECRYPT_KEY_ROT_EN
    exp_ext = 32'h0000_0008;
    exp_amt = 4'd0;
`else
    exp_ext = 32'h0100_0000;
    exp_amt = 4'd2;
`endif
    drive(1'b1, 1'b1, 8'd68);
    n_checks++;
    if (bus.extended_shift_out !== exp_ext) begin
      n_fail++;
      $display("FAIL nl_post_ext got %h want %h", bus.extended_shift_out, exp_ext);
    end
    n_checks++;
    if (bus.shift_amt_out !== exp_amt) begin
      n_fail++;
      $display("FAIL nl_post_amt got %0d want %0d", bus.shift_amt_out, exp_amt);
    end
  endtask

  task automatic test_idle();
    bus.k1 = 8'd3;
    drive(1'b0, 1'b1, 8'd68);
    n_checks++;
    if (bus.extended_shift_out !== 32'd0) begin
      n_fail++;
      $display("FAIL en0_ext got %h want 00000000", bus.extended_shift_out);
    end
    n_checks++;
    if ({bus.shift_amt_out, bus.shift_en_out, bus.is_alpha_upper_case_out,
         bus.is_alpha_low_case_out, bus.en_out, bus.mode_out} !== 9'b0000_00001) begin
      n_fail++;
      $display("FAIL en0_misc got %b want 000000001",
               {bus.shift_amt_out, bus.shift_en_out, bus.is_alpha_upper_case_out,
                bus.is_alpha_low_case_out, bus.en_out, bus.mode_out});
    end
    drive(1'b1, 1'b0, 8'd68);
    n_checks++;
    if (bus.extended_shift_out !== 32'd0) begin
      n_fail++;
      $display("FAIL mode0_ext got %h want 00000000", bus.extended_shift_out);
    end
    n_checks++;
    if ({bus.shift_amt_out, bus.shift_en_out, bus.is_alpha_upper_case_out,
         bus.is_alpha_low_case_out, bus.en_out, bus.mode_out} !== 9'b0000_00010) begin
      n_fail++;
      $display("FAIL mode0_misc got %b want 000000010",
               {bus.shift_amt_out, bus.shift_en_out, bus.is_alpha_upper_case_out,
                bus.is_alpha_low_case_out, bus.en_out, bus.mode_out});
    end
  endtask

  task automatic test_rotation();
    int exp_amt[7];
`ifdef DECRYPT_KEY_ROT_EN
    exp_amt = '{4, 4, 3, 3, 2, 2, 4};
`else
    exp_amt = '{4, 4, 4, 4, 4, 4, 4};
`endif
    bus.rot_freq = 3'd1;
    bus.k1 = 8'd1;
    bus.k2 = 8'd2;
    bus.k3 = 8'd3;
    idle_restart();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 8'd67);
      n_checks++;
      if (bus.extended_shift_out !== 32'h0080_0000) begin
        n_fail++;
        $display("FAIL rot_ext[%0d] got %h want 00800000", i, bus.extended_shift_out);
      end
      n_checks++;
      if (bus.shift_amt_out !== 4'(exp_amt[i])) begin
        n_fail++;
        $display("FAIL rot_amt[%0d] got %0d want %0d", i, bus.shift_amt_out, exp_amt[i]);
      end
    end
  endtask

  task automatic test_restart();
    int exp_amt[6];
`ifdef DECRYPT_KEY_ROT_EN
    exp_amt = '{4, 4, 3, 4, 4, 3};
`else
    exp_amt = '{4, 4, 4, 4, 4, 4};
`endif
    idle_restart();
    for (int i = 0; i < 6; i++) begin
      bus.restart = (i == 3);
      drive(1'b1, 1'b1, 8'd67);
      bus.restart = 1'b0;
      n_checks++;
      if (bus.shift_amt_out !== 4'(exp_amt[i])) begin
        n_fail++;
        $display("FAIL restart_amt[%0d] got %0d want %0d", i, bus.shift_amt_out, exp_amt[i]);
      end
    end
  endtask

  task automatic test_rst_midstream();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd67);
    rst = 1'b0;
    n_checks++;
    if ({bus.en_out, bus.shift_en_out} !== 2'b00 || bus.extended_shift_out !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_out got en_out=%b ext=%h want en_out=0 ext=00000000",
               bus.en_out, bus.extended_shift_out);
    end
    drive(1'b1, 1'b1, 8'd67);
    n_checks++;
    if (bus.shift_amt_out !== 4'd4) begin
      n_fail++;
      $display("FAIL midrst_first_amt got %0d want 4", bus.shift_amt_out);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    bus.din      = 8'd0;
    bus.k1       = 8'd0;
    bus.k2       = 8'd0;
    bus.k3       = 8'd0;
    bus.rot_freq = 3'd7;
    bus.restart  = 1'b0;

    test_reset();
    test_letters();
    test_nonletter();
    test_idle();
    test_rotation();
    test_restart();
    test_rst_midstream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_pipe_onehot.md
# decrypt_pipe_onehot

Decrypt pipeline stage that sits directly upstream of the shift/decode stage. It classifies each incoming ciphertext byte and converts letters to a 26-bit one-hot code. It selects the active key from a rotating three-key schedule and coarse-rotates the one-hot code, leaving a residual shift of 0..6 for the downstream stage. One registered stage, one byte per cycle, no back-pressure.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
- en  in  1  input byte valid
- din  in  8  ciphertext byte (ASCII)
- mode  in  1  1 = decrypt, 0 = encrypt (this stage idle)
- k1, k2, k3  in  8 each  key bytes, unsigned 0..255
- rot_freq  in  3  key advances after rot_freq+1 letters
- restart  in  1  restart key schedule at k1
- en_out  out  1  registered en
- mode_out  out  1  registered mode
- extended_shift_out  out  32  one-hot code (letters) or {24'b0, din} (non-letters)
- shift_amt_out  out  4  residual shift, always 0..6
- shift_en_out  out  1  1 when output is a letter
- is_alpha_upper_case_out  out  1  din in 65..90
- is_alpha_low_case_out  out  1  din in 97..122

## Operation
- Letter index: idx = din-65 (upper) or din-97 (lower), 0..25.
- Active key: K = k1/k2/k3 selected by key_idx (0/1/2).
- Decrypt offset: off = (26 - K mod 26) mod 26. K mod 26 is computed combinationally over the full 8-bit range.
- Split: coarse = 7*floor(off/7), one of {0,7,14,21}; resid = off - coarse, 0..6.
- Letter output:
  - extended_shift_out[25:0] = one-hot(idx) rotated left by coarse, mod 26
  - [31:26] = 0
  - shift_amt_out = resid; shift_en_out = 1
- Non-letter output: extended_shift_out = {24'b0, din}; shift_amt_out = 0; shift_en_out = 0; both case flags 0.
- Schedule state: letter counter cnt (3 bits) and key_idx (2 bits).
- Schedule advances only on cycles with en=1, mode=1 and a letter. On such a cycle:
  - if cnt == rot_freq: cnt <= 0 and key_idx <= (key_idx==2 ? 0 : key_idx+1)
  - else: cnt <= cnt+1
- Non-letters and mode=0 cycles never advance the schedule.
- restart=1: the same-cycle byte uses k1 and is counted as the first letter of the new schedule. Resulting state is cnt=1, key_idx=0, or cnt=0, key_idx=1 if rot_freq=0. With no letter present: cnt=0, key_idx=0.
- en=0 or mode=0:
  - all data outputs register 0
  - en_out = en; mode_out = mode

## Timing
- Latency: 1 cycle from en/din to every output. Throughput: 1 byte/cycle.
- Reset value: every output 0; cnt = 0; key_idx = 0.
- rst mid-stream: takes precedence over en and restart. The byte in that cycle is dropped and en_out = 0 on the next edge.
- Key and rot_freq inputs are sampled every cycle. A change applies to the byte in that same cycle.
- rot_freq changed below the current cnt: the next letter sees cnt != rot_freq and keeps incrementing until 3-bit wrap. This is accepted behaviour; software changes rot_freq only after restart.

## Configuration
- DECRYPT_KEY_ROT_EN defined: three-key rotating schedule as above.
- Not defined:
  - K = k1 always
  - cnt and key_idx are not implemented
  - rot_freq, k2, k3 and restart are ignored
  - all other behaviour is identical

## Test plan
- rst=1 for 2 cycles with en=1, din=65 -> all outputs 0. After release, the first letter uses k1.
- mode=1, k1=3, din='D'(68) -> next cycle extended_shift_out=32'h0100_0000, shift_amt_out=2, shift_en_out=1, upper flag=1. Downstream decodes 'A'.
- k1=0, din='z' -> 32'h0200_0000, amt 0. k1=255, din='a' -> 32'h0000_0001, amt 5 (decodes 'f').
- din='!'(33) between letters -> 32'h0000_0021, shift_en_out=0, flags 0. Key schedule unchanged.
- DECRYPT_KEY_ROT_EN, rot_freq=1, k1=1, k2=2, k3=3, seven consecutive 'C':
  - ext = 32'h0080_0000 for the first six
  - amt = 4,4,3,3,2,2, then 4 (wrap back to k1)
  - downstream decodes B,B,A,A,Z,Z,B
- restart=1 with the 4th letter of the previous case -> that letter uses k1 (amt 4). The next letter uses k1 again, then k2.
